// File: rtl/spmv_csr_engine.sv
// CSR sparse matrix x dense vector engine: streams one signed dot product per row.
// Define SPMV_SAT_EN to make accumulation saturate instead of wrapping.
module spmv_csr_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int ROW_W  = 8,
  parameter int PTR_W  = 10,
  parameter int COL_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_n_rows,
  output logic [ROW_W-1:0]  o_ptr_addr,
  input  logic [PTR_W-1:0]  i_ptr_data,
  output logic [PTR_W-1:0]  o_nz_addr,
  input  logic [COL_W-1:0]  i_col_idx,
  input  logic [DATA_W-1:0] i_val,
  output logic [COL_W-1:0]  o_x_addr,
  input  logic [DATA_W-1:0] i_x_data,
  output logic              o_y_valid,
  output logic [ROW_W-1:0]  o_y_row,
  output logic [ACC_W-1:0]  o_y_data,
  output logic              o_y_sat,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_dbg_state
);

  // Output handshake: o_y_valid is a one-cycle strobe with no back-pressure;
  // o_y_row/o_y_data are valid while it is high and hold until the next strobe.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADP = 3'd1,
    S_LOADE = 3'd2,
    S_FETCH = 3'd3,
    S_MAC   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  n_q, n_d;
  logic [ROW_W-1:0]  r_q, r_d;
  logic [PTR_W-1:0]  k_q, k_d;
  logic [PTR_W-1:0]  end_q, end_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [ROW_W-1:0]  ptr_addr_q, ptr_addr_d;
  logic [PTR_W-1:0]  nz_addr_q, nz_addr_d;
  logic [COL_W-1:0]  x_addr_q, x_addr_d;
  logic [ROW_W-1:0]  y_row_q, y_row_d;
  logic [ACC_W-1:0]  y_data_q, y_data_d;
  logic              err_q, err_d;

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           mac_res;
  logic [PTR_W-1:0]           k_inc;
  logic [ROW_W-1:0]           r_inc;

  assign prod     = $signed(val_q) * $signed(i_x_data);
  assign prod_ext = ACC_W'(prod);
  assign k_inc    = k_q + PTR_W'(1);
  assign r_inc    = r_q + ROW_W'(1);

`ifdef SPMV_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] sum_wide;
  logic           mac_clip;
  logic           rowsat_q, rowsat_d;

  // One extra bit exposes signed overflow as a mismatch of the top two bits.
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign mac_clip = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign mac_res  = mac_clip ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
  assign o_y_sat  = (state_q == S_WRITE) && rowsat_q;
`else
  assign mac_res  = acc_q + prod_ext;
  assign o_y_sat  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    r_d        = r_q;
    k_d        = k_q;
    end_d      = end_q;
    acc_d      = acc_q;
    val_d      = val_q;
    ptr_addr_d = ptr_addr_q;
    nz_addr_d  = nz_addr_q;
    x_addr_d   = x_addr_q;
    y_row_d    = y_row_q;
    y_data_d   = y_data_q;
    err_d      = err_q;
`ifdef SPMV_SAT_EN
    rowsat_d   = rowsat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d   = i_n_rows;
          err_d = 1'b0;
          r_d   = '0;
          if (i_n_rows == '0) begin
            state_d = S_DONE;
          end else begin
            ptr_addr_d = '0;
            state_d    = S_LOADP;
          end
        end
      end
      S_LOADP: begin
        k_d        = i_ptr_data;
        ptr_addr_d = r_inc;
        state_d    = S_LOADE;
      end
      S_LOADE: begin
        end_d = i_ptr_data;
        if (i_ptr_data < k_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (i_ptr_data == k_q) begin
          y_row_d  = r_q;
          y_data_d = acc_q;
          state_d  = S_WRITE;
        end else begin
          nz_addr_d = k_q;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        val_d    = i_val;
        x_addr_d = i_col_idx;
        state_d  = S_MAC;
      end
      S_MAC: begin
        acc_d = mac_res;
        k_d   = k_inc;
`ifdef SPMV_SAT_EN
        rowsat_d = rowsat_q | mac_clip;
`endif
        if (k_inc == end_q) begin
          y_row_d  = r_q;
          y_data_d = mac_res;
          state_d  = S_WRITE;
        end else begin
          nz_addr_d = k_inc;
          state_d   = S_FETCH;
        end
      end
      S_WRITE: begin
        acc_d = '0;
`ifdef SPMV_SAT_EN
        rowsat_d = 1'b0;
`endif
        if (r_inc == n_q) begin
          state_d = S_DONE;
        end else begin
          // k already equals this row's end, so only ptr[r+2] is needed next.
          r_d        = r_inc;
          ptr_addr_d = r_q + ROW_W'(2);
          state_d    = S_LOADE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      r_q        <= '0;
      k_q        <= '0;
      end_q      <= '0;
      acc_q      <= '0;
      val_q      <= '0;
      ptr_addr_q <= '0;
      nz_addr_q  <= '0;
      x_addr_q   <= '0;
      y_row_q    <= '0;
      y_data_q   <= '0;
      err_q      <= 1'b0;
`ifdef SPMV_SAT_EN
      rowsat_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      r_q        <= r_d;
      k_q        <= k_d;
      end_q      <= end_d;
      acc_q      <= acc_d;
      val_q      <= val_d;
      ptr_addr_q <= ptr_addr_d;
      nz_addr_q  <= nz_addr_d;
      x_addr_q   <= x_addr_d;
      y_row_q    <= y_row_d;
      y_data_q   <= y_data_d;
      err_q      <= err_d;
`ifdef SPMV_SAT_EN
      rowsat_q   <= rowsat_d;
`endif
    end
  end

  assign o_ptr_addr  = ptr_addr_q;
  assign o_nz_addr   = nz_addr_q;
  assign o_x_addr    = x_addr_q;
  assign o_y_valid   = (state_q == S_WRITE);
  assign o_y_row     = y_row_q;
  assign o_y_data    = y_data_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_spmv_csr_engine.sv
// Bench for spmv_csr_engine (ACC_W=32): directed table, random CSR vs model, reset abort.
module tb_spmv_csr_engine;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int ROW_W  = 8;
  localparam int PTR_W  = 10;
  localparam int COL_W  = 8;

  logic              i_clk, i_rstn, i_start;
  logic [ROW_W-1:0]  i_n_rows;
  logic [ROW_W-1:0]  o_ptr_addr;
  logic [PTR_W-1:0]  i_ptr_data;
  logic [PTR_W-1:0]  o_nz_addr;
  logic [COL_W-1:0]  i_col_idx;
  logic [DATA_W-1:0] i_val;
  logic [COL_W-1:0]  o_x_addr;
  logic [DATA_W-1:0] i_x_data;
  logic              o_y_valid;
  logic [ROW_W-1:0]  o_y_row;
  logic [ACC_W-1:0]  o_y_data;
  logic              o_y_sat, o_busy, o_done, o_err;
  logic [2:0]        o_dbg_state;

  spmv_csr_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_W(ROW_W), .PTR_W(PTR_W), .COL_W(COL_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_n_rows(i_n_rows),
    .o_ptr_addr(o_ptr_addr), .i_ptr_data(i_ptr_data), .o_nz_addr(o_nz_addr),
    .i_col_idx(i_col_idx), .i_val(i_val), .o_x_addr(o_x_addr), .i_x_data(i_x_data),
    .o_y_valid(o_y_valid), .o_y_row(o_y_row), .o_y_data(o_y_data), .o_y_sat(o_y_sat),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous RAMs: the engine's registered address acts as the RAM address register.
  logic [PTR_W-1:0]  ptr_mem [256];
  logic [COL_W-1:0]  col_mem [1024];
  logic [DATA_W-1:0] val_mem [1024];
  logic [DATA_W-1:0] x_mem   [256];

  assign i_ptr_data = ptr_mem[o_ptr_addr];
  assign i_col_idx  = col_mem[o_nz_addr];
  assign i_val      = val_mem[o_nz_addr];
  assign i_x_data   = x_mem[o_x_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [ROW_W-1:0] exp_row_q[$];
  logic             exp_sat_q[$];

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rstn && o_y_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual_row=%0d expected=none", o_y_row);
      end else begin
        logic [ACC_W-1:0] e;
        logic [ROW_W-1:0] er;
        logic             es;
        e  = exp_q.pop_front();
        er = exp_row_q.pop_front();
        es = exp_sat_q.pop_front();
        check_eq("y_data", longint'($signed(o_y_data)), longint'($signed(e)));
        check_eq("y_row", longint'(o_y_row), longint'(er));
        check_eq("y_sat", longint'(o_y_sat), longint'(es));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin ptr_mem[i] = '0; x_mem[i] = '0; end
    for (int i = 0; i < 1024; i++) begin col_mem[i] = '0; val_mem[i] = '0; end
  endtask

  task automatic run_case(input int n, input int exp_cycles, input bit exp_err,
                          input bit poke, input string name);
    int cyc, busy_cnt;
    bit seen;
    check_eq({name, "_idle_busy"}, longint'(o_busy), 0);
    i_n_rows = ROW_W'(n);
    i_start  = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
      if (o_busy) busy_cnt++;
      if (o_done) seen = 1;
      else if (poke) begin
        i_start  = 1'($urandom_range(0, 1));
        i_n_rows = ROW_W'($urandom);
      end
    end
    i_start = 1'b0;
    check_eq({name, "_done_latency"}, seen ? cyc : -1, exp_cycles);
    check_eq({name, "_busy_cycles"}, busy_cnt, exp_cycles);
    @(negedge i_clk);
    check_eq({name, "_done_one_cycle"}, longint'(o_done), 0);
    check_eq({name, "_busy_cleared"}, longint'(o_busy), 0);
    check_eq({name, "_strobes_left"}, exp_q.size(), 0);
    repeat (3) @(negedge i_clk);
    check_eq({name, "_err"}, longint'(o_err), exp_err);
    exp_q.delete(); exp_row_q.delete(); exp_sat_q.delete();
  endtask

  // Reference: per-row dot product from the CSR arrays, wrap or clamp per accumulate.
  task automatic model_push(input int n, output int cycles);
    longint acc, p;
    bit sat;
    cycles = 2;
    for (int r = 0; r < n; r++) begin
      acc = 0; sat = 0;
      for (int k = int'(ptr_mem[r]); k < int'(ptr_mem[r+1]); k++) begin
        p = longint'($signed(val_mem[k])) * longint'($signed(x_mem[col_mem[k]]));
        acc = acc + p;
`ifdef SPMV_SAT_EN
        if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; sat = 1; end
        if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1; end
`endif
      end
      cycles += 2 + 2 * (int'(ptr_mem[r+1]) - int'(ptr_mem[r]));
      exp_q.push_back(ACC_W'(acc));
      exp_row_q.push_back(ROW_W'(r));
      exp_sat_q.push_back(sat);
    end
  endtask

  typedef struct {
    int n;
    int ptr[9];
    int col[16];
    int val[16];
    int x[8];
    int y[8];
    int nout;
    int sat_mask;
    int cycles;
    bit err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc, rcycles, rn;
    // n = 0
    vecs[0].n = 0;
    vecs[0].ptr = '{0,0,0,0,0,0,0,0,0};
    vecs[0].col = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[0].val = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[0].x = '{0,0,0,0,0,0,0,0};
    vecs[0].y = '{0,0,0,0,0,0,0,0};
    vecs[0].nout = 0; vecs[0].sat_mask = 0; vecs[0].cycles = 1; vecs[0].err = 0;
    // identity 4x4
    vecs[1].n = 4;
    vecs[1].ptr = '{0,1,2,3,4,0,0,0,0};
    vecs[1].col = '{0,1,2,3,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[1].val = '{1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[1].x = '{3,-5,7,9,0,0,0,0};
    vecs[1].y = '{3,-5,7,9,0,0,0,0};
    vecs[1].nout = 4; vecs[1].sat_mask = 0; vecs[1].cycles = 18; vecs[1].err = 0;
    // empty row then two nonzeros
    vecs[2].n = 2;
    vecs[2].ptr = '{0,0,2,0,0,0,0,0,0};
    vecs[2].col = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[2].val = '{2,-4,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[2].x = '{10,6,0,0,0,0,0,0};
    vecs[2].y = '{0,-28,0,0,0,0,0,0};
    vecs[2].nout = 2; vecs[2].sat_mask = 0; vecs[2].cycles = 10; vecs[2].err = 0;
    // malformed pointers: ptr[2] < ptr[1]
    vecs[3].n = 2;
    vecs[3].ptr = '{0,5,3,0,0,0,0,0,0};
    vecs[3].col = '{0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[3].val = '{1,2,3,4,5,0,0,0,0,0,0,0,0,0,0,0};
    vecs[3].x = '{10,20,0,0,0,0,0,0};
    vecs[3].y = '{210,0,0,0,0,0,0,0};
    vecs[3].nout = 1; vecs[3].sat_mask = 0; vecs[3].cycles = 15; vecs[3].err = 1;
    // overflow: three 0x7FFF*0x7FFF products
    vecs[4].n = 1;
    vecs[4].ptr = '{0,3,0,0,0,0,0,0,0};
    vecs[4].col = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[4].val = '{32767,32767,32767,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vecs[4].x = '{32767,0,0,0,0,0,0,0};
`ifdef SPMV_SAT_EN
    vecs[4].y = '{2147483647,0,0,0,0,0,0,0};
    vecs[4].sat_mask = 1;
`else
    vecs[4].y = '{-1073938429,0,0,0,0,0,0,0};
    vecs[4].sat_mask = 0;
`endif
    vecs[4].nout = 1; vecs[4].cycles = 10; vecs[4].err = 0;

    i_rstn = 1'b0; i_start = 1'b0; i_n_rows = '0;
    clear_mems();
    repeat (3) @(negedge i_clk);
    check_eq("reset_busy", longint'(o_busy), 0);
    check_eq("reset_done", longint'(o_done), 0);
    check_eq("reset_valid", longint'(o_y_valid), 0);
    check_eq("reset_ptr_addr", longint'(o_ptr_addr), 0);
    check_eq("reset_y_data", longint'(o_y_data), 0);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      clear_mems();
      for (int i = 0; i < 9; i++)  ptr_mem[i] = PTR_W'(vecs[v].ptr[i]);
      for (int i = 0; i < 16; i++) begin
        col_mem[i] = COL_W'(vecs[v].col[i]);
        val_mem[i] = DATA_W'(vecs[v].val[i]);
      end
      for (int i = 0; i < 8; i++) x_mem[i] = DATA_W'(vecs[v].x[i]);
      for (int i = 0; i < vecs[v].nout; i++) begin
        exp_q.push_back(ACC_W'(vecs[v].y[i]));
        exp_row_q.push_back(ROW_W'(i));
        exp_sat_q.push_back(vecs[v].sat_mask[i]);
      end
      run_case(vecs[v].n, vecs[v].cycles, vecs[v].err, 1'b0, $sformatf("vec%0d", v));
      if (v == 0) begin
        check_eq("n0_ptr_addr", longint'(o_ptr_addr), 0);
        check_eq("n0_nz_addr", longint'(o_nz_addr), 0);
        check_eq("n0_x_addr", longint'(o_x_addr), 0);
      end
    end

    // Random CSR matrices against the model
    for (int t = 0; t < 8; t++) begin
      clear_mems();
      rn = $urandom_range(1, 6);
      ptr_mem[0] = '0;
      for (int r = 0; r < rn; r++)
        ptr_mem[r+1] = ptr_mem[r] + PTR_W'($urandom_range(0, 4));
      for (int k = 0; k < int'(ptr_mem[rn]); k++) begin
        col_mem[k] = COL_W'($urandom_range(0, 7));
        val_mem[k] = DATA_W'($urandom);
      end
      for (int i = 0; i < 8; i++) x_mem[i] = DATA_W'($urandom);
      model_push(rn, rcycles);
      run_case(rn, rcycles, 1'b0, t[0], $sformatf("rand%0d", t));
    end

    // Reset during MAC of row 2 of the identity run
    clear_mems();
    for (int i = 0; i < 9; i++) ptr_mem[i] = PTR_W'(vecs[1].ptr[i]);
    for (int i = 0; i < 16; i++) begin
      col_mem[i] = COL_W'(vecs[1].col[i]);
      val_mem[i] = DATA_W'(vecs[1].val[i]);
    end
    for (int i = 0; i < 8; i++) x_mem[i] = DATA_W'(vecs[1].x[i]);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ACC_W'(vecs[1].y[i]));
      exp_row_q.push_back(ROW_W'(i));
      exp_sat_q.push_back(1'b0);
    end
    i_n_rows = ROW_W'(4);
    i_start  = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    cyc = 0;
    while (cyc < 12) begin
      @(negedge i_clk);
      cyc++;
    end
    i_rstn = 1'b0;
    #1;
    check_eq("abort_busy", longint'(o_busy), 0);
    check_eq("abort_valid", longint'(o_y_valid), 0);
    check_eq("abort_y_data", longint'(o_y_data), 0);
    check_eq("abort_y_row", longint'(o_y_row), 0);
    check_eq("abort_nz_addr", longint'(o_nz_addr), 0);
    check_eq("abort_x_addr", longint'(o_x_addr), 0);
    check_eq("abort_ptr_addr", longint'(o_ptr_addr), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check_eq("abort_no_done", longint'(o_done), 0);
    end
    check_eq("abort_rows_before_reset", exp_q.size(), 0);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);
    check_eq("abort_no_done_after", longint'(o_done), 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ACC_W'(vecs[1].y[i]));
      exp_row_q.push_back(ROW_W'(i));
      exp_sat_q.push_back(1'b0);
    end
    run_case(4, 18, 1'b0, 1'b1, "rerun_identity");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spmv_csr_engine.md
Name: spmv_csr_engine

Overview:
- Parametrised successor to the fixed-width SpMV datapath: computes y = A·x for a CSR-encoded sparse matrix A and a dense vector x.
- Reads row pointers, column indices and values, plus x, from external synchronous RAMs with 1-cycle read latency.
- Streams one signed result per row on a valid-qualified output.
- Sits between the matrix/vector buffers and the result writer; launched by a single start pulse.

Parameters:
- DATA_W, 16, width of matrix values and x elements (signed two's complement).
- ACC_W, 40, accumulator and result width (signed); must be ≥ 2*DATA_W.
- ROW_W, 8, row index / row count width.
- PTR_W, 10, nonzero index (row-pointer value) width.
- COL_W, 8, column index / x address width.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; ignored while o_busy=1.
- i_n_rows  in  ROW_W  number of rows; sampled when start is accepted.
- o_ptr_addr  out  ROW_W  row-pointer RAM address.
- i_ptr_data  in  PTR_W  row-pointer data, valid the cycle after the address.
- o_nz_addr  out  PTR_W  nonzero RAM address, shared by col and val.
- i_col_idx  in  COL_W  column index of the nonzero.
- i_val  in  DATA_W  value of the nonzero.
- o_x_addr  out  COL_W  x RAM address.
- i_x_data  in  DATA_W  x element.
- o_y_valid  out  1  one-cycle result strobe.
- o_y_row  out  ROW_W  row index of the result.
- o_y_data  out  ACC_W  row dot product.
- o_y_sat  out  1  result was clamped (see Optional Feature).
- o_busy  out  1  high from start acceptance until DONE is left.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky malformed-pointer flag; cleared on the next accepted start.

Behaviour:
- Reset (async, active-low):
  - State=IDLE.
  - All outputs 0, including all addresses.
  - Accumulator, row counter r, pointers k and end all 0.
  - Reset mid-operation abandons the run; no o_done is issued.
- All addresses are registered. Data for an address presented in cycle t is consumed in cycle t+1.
- States: IDLE, LOADP, LOADE, FETCH, MAC, WRITE, DONE.
- IDLE:
  - On i_start: latch n=i_n_rows, clear o_err, r=0, o_ptr_addr=0.
  - If n==0, go to DONE; otherwise go to LOADP.
- LOADP: k<=i_ptr_data; o_ptr_addr<=r+1; go to LOADE.
- LOADE: end<=i_ptr_data.
  - If i_ptr_data<k: set o_err, go to DONE.
  - If i_ptr_data==k (empty row): go to WRITE.
  - Otherwise: o_nz_addr<=k, go to FETCH.
- FETCH: latch i_val; o_x_addr<=i_col_idx; go to MAC.
- MAC: acc<=acc+sext(val*i_x_data); k<=k+1.
  - If k+1==end: go to WRITE.
  - Otherwise: o_nz_addr<=k+1, go to FETCH.
- WRITE: o_y_valid=1 for one cycle, o_y_row=r, o_y_data=acc; then acc<=0.
  - If r+1==n: go to DONE.
  - Otherwise: r<=r+1, o_ptr_addr<=r+2, go to LOADE. k already equals end, so ptr[r+1] is not re-read.
- DONE: o_done=1 for one cycle; go to IDLE.
- Cycle count:
  - A row with m nonzeros costs 2+2m cycles.
  - A full run is 1 (LOADP) + Σ(2+2m) + 1 (DONE) cycles after the start cycle.
  - o_busy is high over exactly those cycles.
- Arithmetic:
  - The product is a full 2*DATA_W signed value, sign-extended to ACC_W.
  - Without the optional feature, accumulation wraps modulo 2^ACC_W.
- o_y_row/o_y_data hold their value between strobes.
- Reads of rows ≥ n are never issued.
- The k pointer wraps modulo 2^PTR_W; malformed input beyond that is undefined.

Optional Feature:
- Macro: SPMV_SAT_EN.
- Defined:
  - Each accumulate saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - o_y_sat=1 with o_y_valid if any accumulate for that row clamped.
- Undefined: wrap-around accumulation; o_y_sat tied to 0.

Test Plan:
- Identity 4×4, ptr={0,1,2,3,4}, x={3,−5,7,9}:
  - y rows 0..3 = 3,−5,7,9.
  - o_done exactly 18 cycles after start.
- Rows with ptr={0,0,2}, n=2, row1 val={2,−4}, col={1,0}, x={10,6}:
  - row0 y=0 (empty row path, 2 cycles).
  - row1 y=2·6+(−4)·10=−28.
- Malformed ptr={0,5,3}, n=2:
  - row0 produces 5 products.
  - LOADE for row1 sets o_err, no row1 strobe, o_done pulses.
  - o_err stays 1 until the next start.
- i_n_rows=0:
  - o_busy high 1 cycle, o_done 1 cycle after start.
  - No memory addresses change, no o_y_valid.
- Overflow with ACC_W=32, 3 products of 0x7FFF·0x7FFF in one row:
  - Wrap value without SPMV_SAT_EN.
  - With SPMV_SAT_EN: 0x7FFFFFFF and o_y_sat=1.
- Reset asserted during MAC of row 2; release; new start with the identity case:
  - Outputs are 0 during reset, no o_done from the aborted run.
  - The second run matches scenario 1.
  - i_start pulses while busy are ignored.
